// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key_event block: per-key state encoding
// and the hold-counter width calculation.
package key_event_pkg;

    typedef enum logic [1:0] {
        LOCK    = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        LONG    = 2'd3
    } key_state_t;

    // Wide enough to hold the larger of the two terminal counts.
    function automatic int cnt_width(input int long_c, input int rep_c);
        int m;
        m = (long_c > rep_c) ? long_c : rep_c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_event_chan.sv
// One key channel: lock-out/idle/pressed/long FSM with its hold counter.
// Define SM_KEY_REPEAT_EN to emit auto-repeat press pulses while in LONG.
module key_event_chan
    import key_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_press_next,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_held
);

    localparam int CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
`ifdef SM_KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_TERM = CNT_W'(REPEAT_CYCLES - 1);
`endif

    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic             r_held;
    logic             w_press_next;

    // Exposed so the top can register key_valid/key_code in the same cycle as press.
    always_comb begin
        w_press_next = 1'b0;
        case (r_state)
            IDLE:    w_press_next = ~i_key;
`ifdef SM_KEY_REPEAT_EN
            LONG:    w_press_next = ~i_key && (r_cnt == REP_TERM);
`endif
            default: w_press_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= LOCK;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= w_press_next;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            case (r_state)
                LOCK: begin
                    if (i_key) r_state <= IDLE;
                end
                IDLE: begin
                    if (!i_key) begin
                        r_state <= PRESSED;
                        r_held  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                PRESSED: begin
                    if (i_key) begin
                        r_state   <= IDLE;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                        r_cnt     <= '0;
                    end else if (r_cnt == LONG_TERM) begin
                        r_state <= LONG;
                        r_long  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (i_key) begin
                        r_state   <= IDLE;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
`ifdef SM_KEY_REPEAT_EN
                        if (r_cnt == REP_TERM) r_cnt <= '0;
                        else                   r_cnt <= r_cnt + 1'b1;
`else
                        r_cnt <= '0;
`endif
                    end
                end
                default: r_state <= LOCK;
            endcase
        end
    end

    assign o_press_next = w_press_next;
    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_long       = r_long;
    assign o_held       = r_held;

endmodule

// File: rtl/key_event.sv
// Key event top: NUM_KEYS independent channels plus a registered priority
// encoder for key_valid/key_code. Optional macro: SM_KEY_REPEAT_EN (auto-repeat).
module key_event
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS      = 5,
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    localparam int CODE_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code
);

    logic [NUM_KEYS-1:0] w_press_next;
    logic [CODE_W-1:0]   w_code;
    logic                r_key_valid;
    logic [CODE_W-1:0]   r_key_code;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
        key_event_chan #(
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_key       (key_in[gi]),
            .o_press_next(w_press_next[gi]),
            .o_press     (press_pulse[gi]),
            .o_release   (release_pulse[gi]),
            .o_long      (long_pulse[gi]),
            .o_held      (key_held[gi])
        );
    end

    // Scan downward so the lowest-numbered pressing key wins.
    always_comb begin
        w_code = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_press_next[i]) w_code = CODE_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_key_valid <= |w_press_next;
            r_key_code  <= w_code;
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event (NUM_KEYS=4, LONG_CYCLES=10, REPEAT_CYCLES=4): directed
// scenarios with literal expectations plus randomized keys against a hold-length model.
module tb_key_event;

    localparam int NK   = 4;
    localparam int LONG = 10;
    localparam int REP  = 4;
`ifdef SM_KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_in;
    logic [NK-1:0] press_pulse, release_pulse, long_pulse, key_held;
    logic          key_valid;
    logic [1:0]    key_code;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    key_event #(
        .NUM_KEYS     (NK),
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .key_held     (key_held),
        .key_valid    (key_valid),
        .key_code     (key_code)
    );

    always #5 clk = ~clk;

    // Model: a key is either locked out, free, or held for 'run' samples since its press sample.
    typedef struct packed {
        logic locked;
        logic pressed;
        logic press;
        logic rel;
        logic lng;
        int   run;
    } mk_t;

    localparam mk_t MK_RST = '{locked: 1'b1, pressed: 1'b0, press: 1'b0,
                               rel: 1'b0, lng: 1'b0, run: 0};

    mk_t m [NK];

    function automatic mk_t mstep(input mk_t s, input logic k);
        mk_t n;
        n       = s;
        n.press = 1'b0;
        n.rel   = 1'b0;
        n.lng   = 1'b0;
        if (s.locked) begin
            if (k) n.locked = 1'b0;
        end else if (!k) begin
            if (!s.pressed) begin
                n.press   = 1'b1;
                n.pressed = 1'b1;
                n.run     = 0;
            end else begin
                n.run = s.run + 1;
                if (n.run == LONG) n.lng = 1'b1;
                if (REP_EN && n.run > LONG && ((n.run - LONG) % REP) == 0) n.press = 1'b1;
            end
        end else if (s.pressed) begin
            n.rel     = 1'b1;
            n.pressed = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NK; i++) m[i] <= MK_RST;
        end else begin
            for (int i = 0; i < NK; i++) m[i] <= mstep(m[i], key_in[i]);
        end
    end

    function automatic logic [NK-1:0] exp_vec(input int field);
        logic [NK-1:0] v;
        v = '0;
        for (int i = 0; i < NK; i++) begin
            case (field)
                0:       v[i] = m[i].press;
                1:       v[i] = m[i].rel;
                2:       v[i] = m[i].lng;
                default: v[i] = m[i].pressed;
            endcase
        end
        return v;
    endfunction

    function automatic logic [1:0] exp_code();
        logic [1:0] c;
        c = 2'd0;
        for (int i = NK - 1; i >= 0; i--) if (m[i].press) c = 2'(i);
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, half a cycle after the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("press_pulse",   32'(press_pulse),   32'(exp_vec(0)));
            chk("release_pulse", 32'(release_pulse), 32'(exp_vec(1)));
            chk("long_pulse",    32'(long_pulse),    32'(exp_vec(2)));
            chk("key_held",      32'(key_held),      32'(exp_vec(3)));
            chk("key_valid",     32'(key_valid),     32'(|exp_vec(0)));
            chk("key_code",      32'(key_code),      32'(exp_code()));
        end
    end

    task automatic step(input logic [NK-1:0] k);
        key_in = k;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [NK-1:0] kv;

    initial begin
        rst_n  = 1'b1;
        key_in = 4'b1111;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_outputs", 32'({press_pulse, release_pulse, long_pulse, key_held, key_valid, key_code}), 32'd0);

        // Short press on key 2.
        repeat (4) step(4'b1111);
        step(4'b1011);
        chk("t1_press",  32'(press_pulse), 32'h4);
        chk("t1_valid",  32'(key_valid),   32'h1);
        chk("t1_code",   32'(key_code),    32'h2);
        step(4'b1011);
        step(4'b1011);
        chk("t1_held",   32'(key_held),    32'h4);
        step(4'b1111);
        chk("t1_release", 32'(release_pulse), 32'h4);
        chk("t1_nolong",  32'(long_pulse),    32'h0);

        // Key 0 held for 20 cycles.
        step(4'b1110);
        chk("t2_press", 32'(press_pulse), 32'h1);
        for (int n = 1; n < 20; n++) begin
            step(4'b1110);
            chk("t2_long",  32'(long_pulse),  (n == LONG) ? 32'h1 : 32'h0);
            chk("t2_rep",   32'(press_pulse),
                (REP_EN && n > LONG && ((n - LONG) % REP) == 0) ? 32'h1 : 32'h0);
        end
        step(4'b1111);
        chk("t2_release", 32'(release_pulse), 32'h1);

        // Keys 1 and 3 fall together.
        step(4'b0101);
        chk("t3_press", 32'(press_pulse), 32'hA);
        chk("t3_code",  32'(key_code),    32'h1);
        chk("t3_valid", 32'(key_valid),   32'h1);
        step(4'b0101);
        chk("t3_valid_drop", 32'(key_valid), 32'h0);
        step(4'b1111);

        // Key 0 low through reset release: locked out until it is released.
        key_in = 4'b1110;
        pulse_reset();
        for (int n = 0; n < 5; n++) begin
            step(4'b1110);
            chk("t4_locked_press", 32'(press_pulse), 32'h0);
            chk("t4_locked_held",  32'(key_held),    32'h0);
        end
        step(4'b1111);
        chk("t4_no_release", 32'(release_pulse), 32'h0);
        step(4'b1110);
        chk("t4_press", 32'(press_pulse), 32'h1);
        step(4'b1111);

        // Reset while key 3 is in LONG.
        step(4'b0111);
        chk("t5_press", 32'(press_pulse), 32'h8);
        for (int n = 1; n <= 12; n++) step(4'b0111);
        chk("t5_held_long", 32'(key_held), 32'h8);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_clear", 32'({press_pulse, release_pulse, long_pulse, key_held, key_valid, key_code}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step(4'b0111);
            chk("t5_held_after_rst", 32'(key_held), 32'h0);
        end
        step(4'b1111);
        step(4'b0111);
        chk("t5_repress", 32'(press_pulse), 32'h8);
        step(4'b0111);
        chk("t5_held_again", 32'(key_held), 32'h8);
        step(4'b1111);

        // Randomized key activity with occasional asynchronous resets.
        kv = 4'b1111;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NK; i++) begin
                if ($urandom_range(7) == 0) kv[i] = ~kv[i];
            end
            if ($urandom_range(399) == 0) begin
                key_in = kv;
                pulse_reset();
            end
            step(kv);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
